// File: rtl/reaction_timer.sv
`default_nettype none
// reaction_timer: runs one reaction-time trial (random foreperiod, go LED, ms count)
// and reports OK / EARLY / TIMEOUT with the measured milliseconds.
module reaction_timer #(
  parameter int          CLK_FREQUENCY = 100_000_000,
  parameter int          MIN_DELAY_MS  = 1000,
  parameter int          MAX_WAIT_MS   = 9999,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               btn_start,
  input  logic                               btn_react,
  output logic                               led_go,
  output logic                               busy,
  output logic                               result_valid,
  output logic [1:0]                         result_code,
  output logic [$clog2(MAX_WAIT_MS+1)-1:0]   result_ms
);
  localparam int P  = CLK_FREQUENCY / 1000;
  localparam int PW = $clog2(P);
  localparam int RB = $clog2(MAX_WAIT_MS + 1);
  localparam int DW = $clog2(MIN_DELAY_MS + 1024);

  localparam logic [1:0] C_CODE_OK      = 2'd0;
  localparam logic [1:0] C_CODE_EARLY   = 2'd1;
  localparam logic [1:0] C_CODE_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GO   = 2'd2
  } state_t;

  state_t        state_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] delay_q;
  logic [RB-1:0] elapsed_q;
  logic          start_q, react_q;
  logic          led_go_q, busy_q, valid_q;
  logic [1:0]    code_q;
  logic [RB-1:0] ms_q;
  logic          rise_start, rise_react, tick;

  always_comb begin
    rise_start = btn_start & ~start_q;
    rise_react = btn_react & ~react_q;
    tick       = (presc_q == PW'(P - 1));
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    presc_d    = tick ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    // Button history tracks the inputs even in reset so a held button gives no edge.
    start_q <= btn_start;
    react_q <= btn_react;
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      presc_q   <= '0;
      delay_q   <= '0;
      elapsed_q <= '0;
      led_go_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= C_CODE_OK;
      ms_q      <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= 1'b0;
      presc_q <= presc_d;
      case (state_q)
        S_IDLE: begin
          presc_q <= '0;
          if (rise_start) begin
            state_q <= S_WAIT;
            busy_q  <= 1'b1;
            delay_q <= DW'(MIN_DELAY_MS) + DW'(lfsr_q[9:0]);
          end
        end
        S_WAIT: begin
          if (tick) delay_q <= delay_q - DW'(1);
          if (rise_react) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            code_q  <= C_CODE_EARLY;
            ms_q    <= '0;
          end else if (tick && delay_q <= DW'(1)) begin
            state_q   <= S_GO;
            presc_q   <= '0;
            elapsed_q <= '0;
            led_go_q  <= 1'b1;
          end
        end
        S_GO: begin
          if (tick) elapsed_q <= elapsed_q + RB'(1);
          // React is reported with the count from before any same-cycle tick.
          if (rise_react) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            led_go_q <= 1'b0;
            valid_q  <= 1'b1;
            code_q   <= C_CODE_OK;
            ms_q     <= elapsed_q;
          end else if (tick && elapsed_q == RB'(MAX_WAIT_MS - 1)) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            led_go_q <= 1'b0;
            valid_q  <= 1'b1;
            code_q   <= C_CODE_TIMEOUT;
            ms_q     <= RB'(MAX_WAIT_MS);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign led_go       = led_go_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result_code  = code_q;
  assign result_ms    = ms_q;
endmodule
`default_nettype wire

// File: tb/tb_reaction_timer.sv
`default_nettype none
// tb_reaction_timer: randomized trials checked against a millisecond-level
// behavioural model of the reaction timer.
module tb_reaction_timer;
  localparam int P   = 10;
  localparam int MIN = 5;
  localparam int MAX = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_react = 1'b0;
  logic       led_go, busy, result_valid;
  logic [1:0] result_code;
  logic [4:0] result_ms;

  reaction_timer #(
    .CLK_FREQUENCY(10_000),
    .MIN_DELAY_MS (MIN),
    .MAX_WAIT_MS  (MAX),
    .SEED         (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start   (btn_start),
    .btn_react   (btn_react),
    .led_go      (led_go),
    .busy        (busy),
    .result_valid(result_valid),
    .result_code (result_code),
    .result_ms   (result_ms)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: value visible at a stimulus point is the one a start edge samples.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Event recorder: edge index of every output transition.
  int ev_busy_rise = 0, ev_busy_fall = 0, ev_go_rise = 0, ev_go_fall = 0, ev_valid = 0;
  int n_busy = 0, n_go = 0, n_valid = 0;
  logic [1:0] cap_code = 2'd0;
  logic [4:0] cap_ms = 5'd0;
  bit p_busy = 1'b0, p_go = 1'b0;
  always @(negedge clk) begin
    if (busy === 1'b1 && !p_busy) begin ev_busy_rise = cyc; n_busy++; end
    if (busy !== 1'b1 && p_busy) ev_busy_fall = cyc;
    if (led_go === 1'b1 && !p_go) begin ev_go_rise = cyc; n_go++; end
    if (led_go !== 1'b1 && p_go) ev_go_fall = cyc;
    if (result_valid === 1'b1) begin
      n_valid++; ev_valid = cyc; cap_code = result_code; cap_ms = result_ms;
    end
    p_busy = (busy === 1'b1);
    p_go   = (led_go === 1'b1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_lfsr(input int lo, input int hi);
    for (int i = 0; i < 40000 && !(int'(m_lfsr[9:0]) >= lo && int'(m_lfsr[9:0]) <= hi); i++) step();
  endtask

  // mode 0: never react; 1: react appears k cycles after led_go rises; 2: k cycles after busy rises.
  task automatic run_trial(input int mode, input int k, input bit extra, output int dly, output bit done);
    int lim, v0, g0;
    dly = MIN + int'(m_lfsr[9:0]);
    v0  = n_valid;
    g0  = n_go;
    lim = dly * P + MAX * P + 40;
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    for (int i = 0; i < lim && n_valid == v0; i++) begin
      if (mode == 2 && cyc == ev_busy_rise + k) btn_react = 1'b1;
      if (mode == 1 && n_go != g0 && cyc == ev_go_rise + k) btn_react = 1'b1;
      if (extra && busy === 1'b1 && (i % 5) == 2) btn_start = ~btn_start;
      step();
    end
    done = (n_valid != v0);
    btn_react = 1'b0;
    btn_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (led_go !== 1'b0) begin bad++; $display("FAIL reset_led: got %b want 0", led_go); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    total++; if (result_code !== 2'd0 || result_ms !== 5'd0)
      begin bad++; $display("FAIL reset_result: got code=%0d ms=%0d want 0/0", result_code, result_ms); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_normal();
    int d, v0; bit ok;
    wait_lfsr(0, 15);
    v0 = n_valid;
    run_trial(1, 37, 1'b0, d, ok);
    total++; if (!ok) begin bad++; $display("FAIL normal_done: got no result want result"); end
    total++; if (ev_go_rise - ev_busy_rise != d * P)
      begin bad++; $display("FAIL normal_foreperiod: got %0d want %0d", ev_go_rise - ev_busy_rise, d * P); end
    total++; if (cap_code !== 2'd0) begin bad++; $display("FAIL normal_code: got %0d want 0", cap_code); end
    total++; if (cap_ms !== 5'd3) begin bad++; $display("FAIL normal_ms: got %0d want 3", cap_ms); end
    total++; if (ev_go_fall - ev_go_rise != 38)
      begin bad++; $display("FAIL normal_led_len: got %0d want 38", ev_go_fall - ev_go_rise); end
    total++; if (ev_busy_fall != ev_valid)
      begin bad++; $display("FAIL normal_busy_fall: got %0d want %0d", ev_busy_fall, ev_valid); end
    step(); step();
    total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL normal_pulse: got %0d want 1", n_valid - v0); end
    total++; if (result_ms !== 5'd3) begin bad++; $display("FAIL normal_hold: got %0d want 3", result_ms); end
  endtask

  task automatic test_foreperiod();
    int d; bit ok;
    wait_lfsr(12'h012, 12'h012);
    run_trial(1, 3, 1'b0, d, ok);
    total++; if (!ok || ev_go_rise - ev_busy_rise != 230)
      begin bad++; $display("FAIL foreperiod: got %0d want 230", ev_go_rise - ev_busy_rise); end
    total++; if (cap_code !== 2'd0 || cap_ms !== 5'd0)
      begin bad++; $display("FAIL foreperiod_result: got code=%0d ms=%0d want 0/0", cap_code, cap_ms); end
  endtask

  task automatic test_false_start();
    int d, g0; bit ok;
    wait_lfsr(1, 15);
    g0 = n_go;
    run_trial(2, 50, 1'b0, d, ok);
    total++; if (!ok || cap_code !== 2'd1 || cap_ms !== 5'd0)
      begin bad++; $display("FAIL early_result: got code=%0d ms=%0d want 1/0", cap_code, cap_ms); end
    total++; if (n_go != g0) begin bad++; $display("FAIL early_led: got %0d go pulses want 0", n_go - g0); end
    total++; if (ev_valid - ev_busy_rise != 51)
      begin bad++; $display("FAIL early_latency: got %0d want 51", ev_valid - ev_busy_rise); end
  endtask

  task automatic test_timeout();
    int d; bit ok;
    wait_lfsr(0, 15);
    run_trial(0, 0, 1'b0, d, ok);
    total++; if (!ok || ev_valid - ev_go_rise != MAX * P)
      begin bad++; $display("FAIL timeout_latency: got %0d want %0d", ev_valid - ev_go_rise, MAX * P); end
    total++; if (cap_code !== 2'd2 || cap_ms !== 5'd20)
      begin bad++; $display("FAIL timeout_result: got code=%0d ms=%0d want 2/20", cap_code, cap_ms); end
    total++; if (ev_go_fall != ev_valid || ev_busy_fall != ev_valid)
      begin bad++; $display("FAIL timeout_falls: got led=%0d busy=%0d want %0d", ev_go_fall, ev_busy_fall, ev_valid); end
  endtask

  task automatic test_ties();
    int d, dp, g0; bit ok;
    wait_lfsr(0, 15);
    dp = MIN + int'(m_lfsr[9:0]);
    g0 = n_go;
    run_trial(2, dp * P - 1, 1'b0, d, ok);
    total++; if (!ok || cap_code !== 2'd1 || n_go != g0)
      begin bad++; $display("FAIL tie_wait: got code=%0d go=%0d want 1/0", cap_code, n_go - g0); end
    total++; if (ev_valid - ev_busy_rise != d * P)
      begin bad++; $display("FAIL tie_wait_latency: got %0d want %0d", ev_valid - ev_busy_rise, d * P); end
    wait_lfsr(0, 15);
    run_trial(1, MAX * P - 1, 1'b0, d, ok);
    total++; if (!ok || cap_code !== 2'd0 || cap_ms !== 5'd19)
      begin bad++; $display("FAIL tie_go: got code=%0d ms=%0d want 0/19", cap_code, cap_ms); end
    total++; if (ev_valid - ev_go_rise != MAX * P)
      begin bad++; $display("FAIL tie_go_latency: got %0d want %0d", ev_valid - ev_go_rise, MAX * P); end
  endtask

  task automatic test_mid_go_reset();
    int v0;
    wait_lfsr(0, 15);
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    for (int i = 0; i < 1200 && led_go !== 1'b1; i++) step();
    repeat (5) step();
    v0 = n_valid;
    rst = 1'b1;
    step();
    total++; if (led_go !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0)
      begin bad++; $display("FAIL midreset_flags: got led=%b busy=%b valid=%b want 0/0/0", led_go, busy, result_valid); end
    total++; if (result_code !== 2'd0 || result_ms !== 5'd0)
      begin bad++; $display("FAIL midreset_result: got code=%0d ms=%0d want 0/0", result_code, result_ms); end
    rst = 1'b0;
    repeat (250) step();
    total++; if (n_valid != v0 || busy !== 1'b0)
      begin bad++; $display("FAIL midreset_quiet: got pulses=%0d busy=%b want 0/0", n_valid - v0, busy); end
  endtask

  task automatic test_held_through_reset();
    int b0, v0;
    btn_start = 1'b1;
    btn_react = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    b0 = n_busy;
    v0 = n_valid;
    repeat (30) step();
    total++; if (n_busy != b0 || busy !== 1'b0 || n_valid != v0)
      begin bad++; $display("FAIL held_reset: got busy_rises=%0d pulses=%0d want 0/0", n_busy - b0, n_valid - v0); end
    btn_start = 1'b0;
    btn_react = 1'b0;
    step();
  endtask

  task automatic test_extra_starts();
    int d, b0; bit ok;
    wait_lfsr(0, 15);
    b0 = n_busy;
    run_trial(1, 37, 1'b1, d, ok);
    total++; if (!ok || ev_go_rise - ev_busy_rise != d * P)
      begin bad++; $display("FAIL extra_foreperiod: got %0d want %0d", ev_go_rise - ev_busy_rise, d * P); end
    total++; if (cap_code !== 2'd0 || cap_ms !== 5'd3 || n_busy - b0 != 1)
      begin bad++; $display("FAIL extra_result: got code=%0d ms=%0d trials=%0d want 0/3/1", cap_code, cap_ms, n_busy - b0); end
    step(); step();
  endtask

  task automatic test_back_to_back();
    int d1, d2, e1; bit ok1, ok2;
    wait_lfsr(0, 15);
    run_trial(1, 15, 1'b0, d1, ok1);
    e1 = ev_valid;
    run_trial(2, 30, 1'b0, d2, ok2);
    total++; if (!ok1 || !ok2 || ev_busy_rise != e1 + 1)
      begin bad++; $display("FAIL b2b_restart: got busy at %0d want %0d", ev_busy_rise, e1 + 1); end
    total++; if (cap_code !== 2'd1) begin bad++; $display("FAIL b2b_code: got %0d want 1", cap_code); end
  endtask

  task automatic test_random();
    int mode, k, dp, d, g0; bit ok;
    for (int t = 0; t < 8; t++) begin
      wait_lfsr(0, 15);
      dp   = MIN + int'(m_lfsr[9:0]);
      mode = int'($urandom_range(0, 2));
      k    = (mode == 1) ? int'($urandom_range(0, MAX * P - 1)) : int'($urandom_range(0, dp * P - 1));
      g0   = n_go;
      run_trial(mode, k, 1'b0, d, ok);
      if (mode == 2) begin
        total++; if (!ok || cap_code !== 2'd1 || cap_ms !== 5'd0 || n_go != g0)
          begin bad++; $display("FAIL rand_early k=%0d: got code=%0d ms=%0d want 1/0", k, cap_code, cap_ms); end
      end else if (mode == 1) begin
        total++; if (!ok || cap_code !== 2'd0 || int'(cap_ms) != k / P || ev_valid - ev_go_rise != k + 1)
          begin bad++; $display("FAIL rand_ok k=%0d: got code=%0d ms=%0d want 0/%0d", k, cap_code, cap_ms, k / P); end
      end else begin
        total++; if (!ok || cap_code !== 2'd2 || cap_ms !== 5'd20 || ev_valid - ev_go_rise != MAX * P)
          begin bad++; $display("FAIL rand_timeout: got code=%0d ms=%0d want 2/20", cap_code, cap_ms); end
      end
      if (mode != 2) begin
        total++; if (ev_go_rise - ev_busy_rise != d * P)
          begin bad++; $display("FAIL rand_foreperiod: got %0d want %0d", ev_go_rise - ev_busy_rise, d * P); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_foreperiod();
    test_false_start();
    test_timeout();
    test_mid_go_reset();
    test_ties();
    test_held_through_reset();
    test_extra_starts();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
